// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants, FSM state type and the load formatting helper
// for the data-memory controller.
package dmem_pkg;

  localparam logic [1:0] MASK_B = 2'd0;
  localparam logic [1:0] MASK_H = 2'd1;
  localparam logic [1:0] MASK_W = 2'd2;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  // Pick the addressed byte/half out of an SRAM word and extend it.
  // Any mask other than byte/half (word, reserved) passes the word through.
  function automatic logic [31:0] load_fmt(input logic [31:0] rdata,
                                           input logic [1:0]  off,
                                           input logic [1:0]  mask,
                                           input logic        sext);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{off, 3'b000} +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (mask)
      MASK_B:  return {{24{sext & b[7]}}, b};
      MASK_H:  return {{16{sext & h[15]}}, h};
      default: return rdata;
    endcase
  endfunction

endpackage

// File: rtl/dmem_sram.sv
// dmem_sram: single-port DEPTH_WORDS x 32 SRAM, per-byte write enables,
// registered (1-cycle) read data. No reset: contents and read register
// power up undefined.
// Ports:
//   clk      - clock
//   en_i     - access enable (read or write)
//   we_i     - write enable (qualified by en_i)
//   be_i     - byte write enables
//   idx_i    - word index
//   wdata_i  - write data (already lane-steered)
//   rdata_o  - read data, valid the cycle after an enabled access
module dmem_sram #(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] idx_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Read-before-write on the same port; a store's read data is never used.
  always_ff @(posedge clk) begin
    if (en_i) begin
      rdata_q <= mem_q[idx_i];
      if (we_i) begin
        for (int b = 0; b < 4; b++) begin
          if (be_i[b]) mem_q[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller between the pipeline's dmem adapter and
// a synchronous-read word SRAM. Does byte-lane steering, byte-enable
// generation and load alignment / sign extension. Two-state FSM: a request
// is accepted in IDLE, answered with a one-cycle dmem_ready in RESP.
// Optional feature macro: DMEM_MISALIGN_CHECK_EN -- flags misaligned
// half/word accesses (dmem_err, write suppressed, data 0). Without it,
// misaligned half/word addresses are rounded down and proceed.
// Ports:
//   clk, reset_n     - clock, async active-low reset
//   dmem_valid       - request present (held until dmem_ready)
//   dmem_addr        - byte address (bits above AW+1 ignored)
//   dmem_writeData   - right-justified store data
//   dmem_memRead     - load request
//   dmem_memWrite    - store request (wins over load when both set)
//   dmem_maskMode    - 0 byte, 1 half, 2/3 word
//   dmem_sext        - sign-extend load result
//   dmem_readData    - formatted load data (held after response)
//   dmem_ready       - one-cycle completion pulse
//   dmem_err         - misaligned access, pulses with dmem_ready
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_writeData,
  input  logic        dmem_memRead,
  input  logic        dmem_memWrite,
  input  logic [1:0]  dmem_maskMode,
  input  logic        dmem_sext,
  output logic [31:0] dmem_readData,
  output logic        dmem_ready,
  output logic        dmem_err
);

  state_e      state_q, state_d;
  logic        accept;
  logic [1:0]  mask_eff;
  logic        is_h, is_w;
  logic        err_req;
  logic [1:0]  off;
  logic [3:0]  be;
  logic [31:0] wdata_rep;
  logic        sram_en, sram_we;
  logic [31:0] sram_rdata;
  logic [31:0] fmt_data;

  logic [1:0]  off_q, off_d;
  logic [1:0]  mask_q, mask_d;
  logic        sext_q, sext_d;
  logic        rd_q, rd_d;
  logic [31:0] hold_q, hold_d;

  // Upper address bits alias; consumed here only to document that.
  logic unused_addr_hi;
  assign unused_addr_hi = ^dmem_addr[31:AW+2];

  assign accept   = (state_q == IDLE) && dmem_valid;
  assign mask_eff = (dmem_maskMode == 2'd3) ? MASK_W : dmem_maskMode;
  assign is_h     = (mask_eff == MASK_H);
  assign is_w     = (mask_eff == MASK_W);

`ifdef DMEM_MISALIGN_CHECK_EN
  logic err_q, err_d;
  assign err_req = (is_h & dmem_addr[0]) | (is_w & (|dmem_addr[1:0]));
  assign off     = dmem_addr[1:0];
`else
  assign err_req = 1'b0;
  // Round misaligned half/word addresses down to their natural boundary.
  assign off     = is_w ? 2'b00 : (is_h ? {dmem_addr[1], 1'b0} : dmem_addr[1:0]);
`endif

  always_comb begin
    be        = 4'b1111;
    wdata_rep = dmem_writeData;
    case (mask_eff)
      MASK_B: begin
        be        = 4'b0001 << off;
        wdata_rep = {4{dmem_writeData[7:0]}};
      end
      MASK_H: begin
        be        = 4'b0011 << {off[1], 1'b0};
        wdata_rep = {2{dmem_writeData[15:0]}};
      end
      default: ;
    endcase
  end

  // A flagged request never touches the SRAM; no-op requests don't either.
  assign sram_en = accept && (dmem_memRead || dmem_memWrite) && !err_req;
  assign sram_we = accept && dmem_memWrite && !err_req;

  dmem_sram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_sram (
    .clk    (clk),
    .en_i   (sram_en),
    .we_i   (sram_we),
    .be_i   (be),
    .idx_i  (dmem_addr[AW+1:2]),
    .wdata_i(wdata_rep),
    .rdata_o(sram_rdata)
  );

  // Only a pure, non-flagged load returns data; store, load+store, no-op
  // and misaligned requests all return 0.
  assign fmt_data = rd_q ? load_fmt(sram_rdata, off_q, mask_q, sext_q) : 32'h0;

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    mask_d  = mask_q;
    sext_d  = sext_q;
    rd_d    = rd_q;
    hold_d  = hold_q;
`ifdef DMEM_MISALIGN_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (dmem_valid) begin
          off_d   = off;
          mask_d  = mask_eff;
          sext_d  = dmem_sext;
          rd_d    = dmem_memRead && !dmem_memWrite && !err_req;
`ifdef DMEM_MISALIGN_CHECK_EN
          err_d   = err_req;
`endif
          state_d = RESP;
        end
      end
      RESP: begin
        hold_d  = fmt_data;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      off_q   <= 2'b00;
      mask_q  <= 2'b00;
      sext_q  <= 1'b0;
      rd_q    <= 1'b0;
      hold_q  <= 32'h0;
`ifdef DMEM_MISALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      mask_q  <= mask_d;
      sext_q  <= sext_d;
      rd_q    <= rd_d;
      hold_q  <= hold_d;
`ifdef DMEM_MISALIGN_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign dmem_ready    = (state_q == RESP);
  assign dmem_readData = (state_q == RESP) ? fmt_data : hold_q;
`ifdef DMEM_MISALIGN_CHECK_EN
  assign dmem_err      = (state_q == RESP) && err_q;
`else
  assign dmem_err      = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed self-checking bench for dmem_ctrl.
module tb_dmem_ctrl;

`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit MC = 1'b1;
`else
  localparam bit MC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        dmem_valid = 1'b0;
  logic [31:0] dmem_addr = '0;
  logic [31:0] dmem_writeData = '0;
  logic        dmem_memRead = 1'b0;
  logic        dmem_memWrite = 1'b0;
  logic [1:0]  dmem_maskMode = '0;
  logic        dmem_sext = 1'b0;
  logic [31:0] dmem_readData;
  logic        dmem_ready;
  logic        dmem_err;

  int total = 0;
  int bad   = 0;
  logic [31:0] w10;

  always #5 clk = ~clk;

  dmem_ctrl #(.DEPTH_WORDS(4096)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .dmem_valid    (dmem_valid),
    .dmem_addr     (dmem_addr),
    .dmem_writeData(dmem_writeData),
    .dmem_memRead  (dmem_memRead),
    .dmem_memWrite (dmem_memWrite),
    .dmem_maskMode (dmem_maskMode),
    .dmem_sext     (dmem_sext),
    .dmem_readData (dmem_readData),
    .dmem_ready    (dmem_ready),
    .dmem_err      (dmem_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full request: accept edge, RESP checks, then post-RESP hold checks.
  task automatic req(input string tag, input logic [31:0] a, input logic [31:0] wd,
                     input logic rd, input logic wr, input logic [1:0] m, input logic sx,
                     input logic [31:0] exp, input logic exp_err);
    @(negedge clk);
    dmem_valid = 1'b1; dmem_addr = a; dmem_writeData = wd;
    dmem_memRead = rd; dmem_memWrite = wr; dmem_maskMode = m; dmem_sext = sx;
    @(posedge clk); #1;
    chk({tag, ".ready"}, {31'b0, dmem_ready}, 32'd1);
    chk({tag, ".data"},  dmem_readData, exp);
    chk({tag, ".err"},   {31'b0, dmem_err}, {31'b0, exp_err});
    @(negedge clk);
    dmem_valid = 1'b0; dmem_memRead = 1'b0; dmem_memWrite = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".ready_drop"}, {31'b0, dmem_ready}, 32'd0);
    chk({tag, ".hold"},       dmem_readData, exp);
  endtask

  initial begin
    #12;
    chk("rst.ready", {31'b0, dmem_ready}, 32'd0);
    chk("rst.err",   {31'b0, dmem_err}, 32'd0);
    chk("rst.data",  dmem_readData, 32'h0);
    @(negedge clk); reset_n = 1'b1;

    // word store/load
    req("sw10", 32'h10, 32'hDEADBEEF, 0, 1, 2'd2, 0, 32'h0, 0);
    req("lw10", 32'h10, 32'h0,        1, 0, 2'd2, 0, 32'hDEADBEEF, 0);

    // byte store (only low byte of data counts), signed/unsigned loads
    req("sb13",  32'h13, 32'h12345680, 0, 1, 2'd0, 0, 32'h0, 0);
    req("lb13",  32'h13, 32'h0, 1, 0, 2'd0, 1, 32'hFFFFFF80, 0);
    req("lbu13", 32'h13, 32'h0, 1, 0, 2'd0, 0, 32'h00000080, 0);
    req("lw10b", 32'h10, 32'h0, 1, 0, 2'd2, 0, 32'h80ADBEEF, 0);

    // half store/load
    req("sh12",  32'h12, 32'hABCD8001, 0, 1, 2'd1, 0, 32'h0, 0);
    req("lh12",  32'h12, 32'h0, 1, 0, 2'd1, 1, 32'hFFFF8001, 0);
    req("lw10c", 32'h10, 32'h0, 1, 0, 2'd2, 0, 32'h8001BEEF, 0);

    // misaligned half load @0x11: flagged, or reads half @0x10
    req("lh11", 32'h11, 32'h0, 1, 0, 2'd1, 1, MC ? 32'h0 : 32'hFFFFBEEF, MC);
    // misaligned half store @0x11: suppressed, or writes half @0x10
    req("sh11", 32'h11, 32'h00001234, 0, 1, 2'd1, 0, 32'h0, MC);
    w10 = MC ? 32'h8001BEEF : 32'h80011234;
    req("lw10d", 32'h10, 32'h0, 1, 0, 2'd2, 0, w10, 0);
    // misaligned word load @0x12
    req("lw12", 32'h12, 32'h0, 1, 0, 2'd2, 0, MC ? 32'h0 : w10, MC);

    // reserved mask acts as word; unsigned byte at lane 0
    req("lw10m3", 32'h10, 32'h0, 1, 0, 2'd3, 0, w10, 0);
    req("lbu10",  32'h10, 32'h0, 1, 0, 2'd0, 0, {24'h0, w10[7:0]}, 0);

    // address aliasing
    req("lw4010", 32'h4010, 32'h0, 1, 0, 2'd2, 0, w10, 0);
    req("sw4020", 32'h4020, 32'hCAFEF00D, 0, 1, 2'd2, 0, 32'h0, 0);
    req("lw20",   32'h20, 32'h0, 1, 0, 2'd2, 0, 32'hCAFEF00D, 0);

    // read+write together: write done, data 0
    req("rw30", 32'h30, 32'h11223344, 1, 1, 2'd2, 0, 32'h0, 0);
    req("lw30", 32'h30, 32'h0, 1, 0, 2'd2, 0, 32'h11223344, 0);
    // no-op request
    req("nop",  32'h30, 32'h0, 0, 0, 2'd2, 0, 32'h0, 0);

    // load leaves nonzero in hold, then reset in RESP of the next load
    req("lw30b", 32'h30, 32'h0, 1, 0, 2'd2, 0, 32'h11223344, 0);
    @(negedge clk);
    dmem_valid = 1'b1; dmem_addr = 32'h20; dmem_memRead = 1'b1;
    dmem_memWrite = 1'b0; dmem_maskMode = 2'd2; dmem_sext = 1'b0;
    @(posedge clk); #1;
    chk("rstresp.ready_pre", {31'b0, dmem_ready}, 32'd1);
    chk("rstresp.data_pre",  dmem_readData, 32'hCAFEF00D);
    #2 reset_n = 1'b0;
    #1;
    chk("rstresp.ready", {31'b0, dmem_ready}, 32'd0);
    chk("rstresp.data",  dmem_readData, 32'h0);
    @(negedge clk);
    dmem_valid = 1'b0; dmem_memRead = 1'b0;
    reset_n = 1'b1;
    req("lw20post", 32'h20, 32'h0, 1, 0, 2'd2, 0, 32'hCAFEF00D, 0);
    req("lw10post", 32'h10, 32'h0, 1, 0, 2'd2, 0, w10, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory controller that sits directly downstream of the pipeline's dmem read/write adapter. It consumes that adapter's `dmem_*` request bus and drives a single-port, synchronous-read word SRAM. It performs byte-lane steering, byte-enable generation and load alignment/sign extension. It returns load data with a ready handshake that the pipeline uses as its memory stall.

## Interface
Parameters:
- `DEPTH_WORDS`, 4096: SRAM depth in 32-bit words; power of two.
- `AW`, `$clog2(DEPTH_WORDS)`: word-index width, taken from `dmem_addr[AW+1:2]`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `dmem_valid` in 1: request present; held stable by the requester until `dmem_ready`.
- `dmem_addr` in 32: byte address.
- `dmem_writeData` in 32: store data, right-justified.
- `dmem_memRead` in 1: load request.
- `dmem_memWrite` in 1: store request.
- `dmem_maskMode` in 2: access size; 0 = byte, 1 = half, 2 = word, 3 = reserved (treated as word).
- `dmem_sext` in 1: sign-extend load result.
- `dmem_readData` out 32: aligned and extended load data.
- `dmem_ready` out 1: request complete, one-cycle pulse.
- `dmem_err` out 1: misaligned access, pulses with `dmem_ready`.

## Operation
- FSM states: IDLE, RESP.
- IDLE, `dmem_valid`=1: request accepted this cycle.
  - SRAM enable and index are driven combinationally from the inputs.
  - Store: write enable, replicated data and byte enables go to the SRAM. The write commits at this edge.
  - The block registers byte offset `addr[1:0]`, maskMode, sext, read flag and error flag.
  - Next state is RESP.
- RESP: `dmem_ready`=1 for one cycle, then IDLE unconditionally. There is no back-to-back accept, so throughput is one request per 2 cycles.
- Byte enables:
  - byte: `4'b0001 << addr[1:0]`.
  - half: `4'b0011 << {addr[1],1'b0}`.
  - word: `4'b1111`.
- Store data replication:
  - byte: `{4{wd[7:0]}}`.
  - half: `{2{wd[15:0]}}`.
  - word: `wd`.
- Load extraction in RESP: select the byte or half from the SRAM output using the registered offset. Zero-extend, or sign-extend from bit 7/15 when `sext`=1. Word loads pass through unchanged.
- `dmem_readData` is driven from the formatted SRAM output during RESP. It is captured into a hold register at the RESP edge and stays stable until the next RESP.
- Store-only or no-op requests return `dmem_readData`=0 in RESP and the hold register is set to 0.
- `dmem_memRead` and `dmem_memWrite` both high: the write is performed, the read is ignored, and the returned data is 0.
- `dmem_valid` with neither read nor write set: no SRAM access, RESP with data 0.

## Timing
- Reset values: state IDLE, `dmem_ready`=0, `dmem_err`=0, `dmem_readData`=0, all registers 0. SRAM contents are not reset.
- Latency: request accepted in cycle N, `dmem_ready`/`dmem_readData` valid in cycle N+1.
- SRAM read latency is 1 cycle (registered output).
- Reset asserted in RESP: the response is lost and `dmem_ready` drops immediately. A write that committed at the accept edge remains in the SRAM.
- `dmem_valid` deasserted in RESP has no effect; the response is still produced.
- Address bits above `AW+1` are ignored, so addresses wrap modulo `DEPTH_WORDS*4`.

## Configuration
- `DMEM_MISALIGN_CHECK_EN` defined:
  - A half access with `addr[0]`=1, or a word access with `addr[1:0]`≠0, is flagged.
  - The SRAM write is suppressed, `dmem_readData`=0, and `dmem_err`=1 in RESP.
- Not defined:
  - `dmem_err` is tied 0.
  - Half accesses force `addr[0]`=0 and word accesses force `addr[1:0]`=0, and proceed normally.

## Structure
- `dmem_pkg`: constants `MASK_B`=2'd0, `MASK_H`=2'd1, `MASK_W`=2'd2, and the FSM state enum (IDLE, RESP).
- Sub-module `dmem_sram`: `DEPTH_WORDS`×32, single port, 4 byte-write enables, registered read data. It contains no reset logic.
- The controller holds the FSM, steering and extraction logic.

## Test plan
- Word store 0xDEADBEEF @0x10, then word load @0x10 → `dmem_ready` at N+1, data 0xDEADBEEF.
- Byte store 0x80 @0x13, then byte load @0x13: with sext → 0xFFFFFF80; without sext → 0x00000080. Word load @0x10 → 0x80ADBEEF.
- Half store 0x8001 @0x12, then half load sext @0x12 → 0xFFFF8001. Word @0x10 → 0x8001BEEF.
- Half load @0x11 with macro → `dmem_err`=1, data 0, no SRAM change. Without macro → reads half @0x10.
- Reset asserted during RESP of a load → `dmem_ready`/`dmem_readData` 0 immediately. The prior store is still readable afterward.
- Address 0x4010 with `DEPTH_WORDS`=4096 → aliases 0x0010.
